// File: rtl/muskbus_line_writer_pkg.sv
// Shared Muskbus definitions: request tag fields and the line-writer FSM encoding.
`timescale 1ns/1ps
package muskbus_line_writer_pkg;

    localparam int unsigned MUSK_TAG_W  = 16;
    localparam logic [3:0]  MUSK_WRITE  = 4'h1;
    localparam logic [3:0]  MUSK_MEMORY = 4'h2;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } writer_state_t;

endpackage

// File: rtl/muskbus_if.sv
// Muskbus request/response signal bundle; Top is the initiator's view.
`timescale 1ns/1ps
interface Muskbus;
    import muskbus_line_writer_pkg::*;

    logic                  reqcyc;
    logic                  reqack;
    logic [63:0]           req;
    logic [MUSK_TAG_W-1:0] reqtag;
    logic                  respcyc;
    logic                  respack;
    logic [MUSK_TAG_W-1:0] resptag;

    modport Top (
        output reqcyc,
        output req,
        output reqtag,
        output respack,
        input  reqack,
        input  respcyc,
        input  resptag
    );

endinterface

// File: rtl/muskbus_line_writer_line_hold_reg.sv
// One-entry valid/ready holding register for a line-aligned address and line data.
`timescale 1ns/1ps
module line_hold_reg #(
    parameter int unsigned LINE_W = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_addr,
    input  logic [0:LINE_W-1] in_data,
    output logic              out_valid,
    input  logic              out_take,
    output logic [63:0]       out_addr,
    output logic [0:LINE_W-1] out_data
);

    logic              valid_q, valid_d;
    logic [63:0]       addr_q, addr_d;
    logic [0:LINE_W-1] data_q, data_d;

    // Take and load are mutually exclusive: take needs valid_q, load needs !valid_q.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (out_take) begin
            valid_d = 1'b0;
        end
        if (in_valid && !valid_q) begin
            valid_d = 1'b1;
            addr_d  = in_addr & ~64'h3F;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;

endmodule

// File: rtl/muskbus_line_writer.sv
// Muskbus write initiator: one address beat plus eight 64-bit data beats per line, then waits for the ack.
`timescale 1ns/1ps
module muskbus_line_writer
    import muskbus_line_writer_pkg::*;
#(
    parameter logic [7:0]  TAG_ID     = 8'd1,
    parameter int unsigned DATA_BEATS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [63:0]              wr_addr,
    input  logic [0:64*DATA_BEATS-1] wr_data,
    output logic                     wr_done,
    output logic                     busy,
    Muskbus.Top                      bus
);

    localparam int unsigned LINE_W    = 64 * DATA_BEATS;
    localparam logic [2:0]  LAST_BEAT = 3'(DATA_BEATS - 1);

    writer_state_t     state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [63:0]       act_addr_q, act_addr_d;
    logic [0:LINE_W-1] act_data_q, act_data_d;
    logic              wr_done_q, wr_done_d;

    logic              hold_valid, hold_take;
    logic [63:0]       hold_addr;
    logic [0:LINE_W-1] hold_data;
    logic              resp_match;
    logic [63:0]       beat_word;
    logic [7:0]        unused_tag_hi;

    line_hold_reg #(.LINE_W(LINE_W)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wr_valid),
        .in_ready  (wr_ready),
        .in_addr   (wr_addr),
        .in_data   (wr_data),
        .out_valid (hold_valid),
        .out_take  (hold_take),
        .out_addr  (hold_addr),
        .out_data  (hold_data)
    );

    assign resp_match    = (state_q == RESP) && bus.respcyc && (bus.resptag[7:0] == TAG_ID);
    assign unused_tag_hi = bus.resptag[15:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            act_addr_q <= '0;
            act_data_q <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            act_addr_q <= act_addr_d;
            act_data_q <= act_data_d;
            wr_done_q  <= wr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        act_addr_d = act_addr_q;
        act_data_d = act_data_q;
        hold_take  = 1'b0;
        wr_done_d  = resp_match;
        case (state_q)
            IDLE: if (hold_valid) begin
                hold_take  = 1'b1;
                act_addr_d = hold_addr;
                act_data_d = hold_data;
                state_d    = ADDR;
            end
            ADDR: if (bus.reqack) begin
                beat_d  = '0;
                state_d = DATA;
            end
            DATA: if (bus.reqack) begin
                if (beat_q == LAST_BEAT) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            RESP: if (resp_match) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte 0 of each beat goes to req[7:0] (little-endian on the bus).
    always_comb begin
        beat_word = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            beat_word[8*b +: 8] = act_data_q[(32'(beat_q) * 8 + b) * 8 +: 8];
        end
    end

    always_comb begin
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        case (state_q)
            ADDR: begin
                bus.reqcyc = 1'b1;
                bus.req    = act_addr_q;
                bus.reqtag = {MUSK_WRITE, MUSK_MEMORY, TAG_ID};
            end
            DATA: begin
                bus.reqcyc = 1'b1;
                bus.req    = beat_word;
                bus.reqtag = {MUSK_WRITE, MUSK_MEMORY, TAG_ID};
            end
            RESP: bus.respack = resp_match;
            default: ;
        endcase
    end

    assign wr_done = wr_done_q;
    assign busy    = (state_q != IDLE) || hold_valid;

endmodule

// File: tb/tb_muskbus_line_writer.sv
// Directed bench for muskbus_line_writer: drives the Muskbus target side by hand and checks beats and handshakes.
`timescale 1ns/1ps
module tb_muskbus_line_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [63:0]  wr_addr;
    logic [0:511] wr_data;
    logic         wr_done;
    logic         busy;

    Muskbus bus_if();

    int total = 0;
    int bad   = 0;

    logic [63:0] cap [9];
    logic [15:0] cap_tag;
    logic        cap_stable;
    logic        cap_tmo;

    always #5 clk = ~clk;

    muskbus_line_writer #(.TAG_ID(8'd1), .DATA_BEATS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .busy     (busy),
        .bus      (bus_if)
    );

    function automatic logic [0:511] make_line(input logic [7:0] base);
        logic [0:511] d;
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] exp_beat(input logic [7:0] base, input int k);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = base + 8'(8*k + b);
        return r;
    endfunction

    task automatic send_req(input logic [63:0] addr, input logic [7:0] base);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = make_line(base);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Acts as the bus target for one line (address + 8 data beats), optionally stalling two beats.
    task automatic capture_line(input int stall_a, input int stall_b);
        int st;
        int waited;
        cap_stable = 1'b1;
        cap_tmo    = 1'b0;
        for (int k = 0; k < 9; k++) begin
            st = (k == 1) ? stall_a : (k == 6) ? stall_b : 0;
            bus_if.reqack = 1'b0;
            #1;
            waited = 0;
            while (!bus_if.reqcyc && waited < 20) begin
                @(negedge clk); #1;
                waited++;
            end
            if (!bus_if.reqcyc) begin
                cap_tmo = 1'b1;
                return;
            end
            cap[k] = bus_if.req;
            if (k == 0) cap_tag = bus_if.reqtag;
            for (int s = 0; s < st; s++) begin
                @(negedge clk); #1;
                if (bus_if.req !== cap[k] || bus_if.reqcyc !== 1'b1) cap_stable = 1'b0;
            end
            bus_if.reqack = 1'b1;
            @(negedge clk);
        end
        bus_if.reqack = 1'b0;
    endtask

    task automatic respond(input logic [15:0] tag, output logic ack);
        bus_if.respcyc = 1'b1;
        bus_if.resptag = tag;
        #1;
        ack = bus_if.respack;
        @(negedge clk);
        bus_if.respcyc = 1'b0;
        bus_if.resptag = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (wr_ready !== 1'b1 || wr_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl wr_ready=%b wr_done=%b busy=%b expected 1 0 0", wr_ready, wr_done, busy);
        end
        total++;
        if (bus_if.reqcyc !== 1'b0 || bus_if.respack !== 1'b0 || bus_if.req !== 64'h0 || bus_if.reqtag !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus reqcyc=%b respack=%b req=%h reqtag=%h expected all zero",
                     bus_if.reqcyc, bus_if.respack, bus_if.req, bus_if.reqtag);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic ack;
        send_req(64'h1040, 8'h00);
        #1;
        total++;
        if (bus_if.reqcyc !== 1'b0 || wr_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_held reqcyc=%b wr_ready=%b busy=%b expected 0 0 1", bus_if.reqcyc, wr_ready, busy);
        end
        @(negedge clk); #1;
        total++;
        if (bus_if.reqcyc !== 1'b1 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_latency reqcyc=%b wr_ready=%b expected 1 1", bus_if.reqcyc, wr_ready);
        end
        capture_line(0, 0);
        total++;
        if (cap_tmo !== 1'b0) begin bad++; $display("FAIL single_timeout got=1 expected=0"); end
        total++;
        if (cap[0] !== 64'h1040) begin bad++; $display("FAIL single_addr got=%h expected=%h", cap[0], 64'h1040); end
        total++;
        if (cap_tag !== 16'h1201) begin bad++; $display("FAIL single_tag got=%h expected=1201", cap_tag); end
        for (int k = 1; k < 9; k++) begin
            total++;
            if (cap[k] !== exp_beat(8'h00, k - 1)) begin
                bad++;
                $display("FAIL single_beat%0d got=%h expected=%h", k - 1, cap[k], exp_beat(8'h00, k - 1));
            end
        end
        #1;
        total++;
        if (bus_if.reqcyc !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_in_resp reqcyc=%b busy=%b expected 0 1", bus_if.reqcyc, busy);
        end
        respond(16'h0001, ack);
        total++;
        if (ack !== 1'b1) begin bad++; $display("FAIL single_respack got=%b expected=1", ack); end
        #1;
        total++;
        if (wr_done !== 1'b1) begin bad++; $display("FAIL single_done got=%b expected=1", wr_done); end
        @(negedge clk); #1;
        total++;
        if (wr_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done_pulse wr_done=%b busy=%b expected 0 0", wr_done, busy);
        end
    endtask

    task automatic test_unaligned();
        logic ack;
        send_req(64'h107F, 8'h40);
        capture_line(0, 0);
        total++;
        if (cap_tmo !== 1'b0 || cap[0] !== 64'h1040) begin
            bad++;
            $display("FAIL unaligned_addr got=%h tmo=%b expected=%h", cap[0], cap_tmo, 64'h1040);
        end
        total++;
        if (cap[1] !== 64'h4746454443424140 || cap[8] !== 64'h7F7E7D7C7B7A7978) begin
            bad++;
            $display("FAIL unaligned_data beat0=%h beat7=%h expected 4746454443424140 7F7E7D7C7B7A7978", cap[1], cap[8]);
        end
        respond(16'h0001, ack);
        #1;
        total++;
        if (ack !== 1'b1 || wr_done !== 1'b1) begin
            bad++;
            $display("FAIL unaligned_done respack=%b wr_done=%b expected 1 1", ack, wr_done);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic ack;
        send_req(64'h2240, 8'h10);
        capture_line(3, 3);
        total++;
        if (cap_tmo !== 1'b0 || cap_stable !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold tmo=%b stable=%b expected 0 1", cap_tmo, cap_stable);
        end
        for (int k = 1; k < 9; k++) begin
            total++;
            if (cap[k] !== exp_beat(8'h10, k - 1)) begin
                bad++;
                $display("FAIL stall_beat%0d got=%h expected=%h", k - 1, cap[k], exp_beat(8'h10, k - 1));
            end
        end
        #1;
        total++;
        if (bus_if.reqcyc !== 1'b0) begin bad++; $display("FAIL stall_beat_count reqcyc=%b expected=0", bus_if.reqcyc); end
        respond(16'h0001, ack);
        #1;
        total++;
        if (ack !== 1'b1 || wr_done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done respack=%b wr_done=%b expected 1 1", ack, wr_done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic ack;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 64'h4000;
        wr_data  = make_line(8'h20);
        @(negedge clk); #1;
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b expected=0", wr_ready); end
        wr_addr = 64'h5000;
        wr_data = make_line(8'hA0);
        @(negedge clk); #1;
        total++;
        if (wr_ready !== 1'b1 || bus_if.reqcyc !== 1'b1 || bus_if.req !== 64'h4000) begin
            bad++;
            $display("FAIL b2b_act_load wr_ready=%b reqcyc=%b req=%h expected 1 1 4000", wr_ready, bus_if.reqcyc, bus_if.req);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        total++;
        if (wr_ready !== 1'b0 || bus_if.req !== 64'h4000) begin
            bad++;
            $display("FAIL b2b_second_accept wr_ready=%b req=%h expected 0 4000", wr_ready, bus_if.req);
        end
        capture_line(0, 0);
        total++;
        if (cap_tmo !== 1'b0 || cap[0] !== 64'h4000 || cap[1] !== exp_beat(8'h20, 0) || cap[8] !== exp_beat(8'h20, 7)) begin
            bad++;
            $display("FAIL b2b_line_a addr=%h beat0=%h beat7=%h tmo=%b expected 4000 %h %h 0",
                     cap[0], cap[1], cap[8], cap_tmo, exp_beat(8'h20, 0), exp_beat(8'h20, 7));
        end
        respond(16'h0001, ack);
        #1;
        total++;
        if (ack !== 1'b1 || wr_done !== 1'b1 || bus_if.reqcyc !== 1'b0) begin
            bad++;
            $display("FAIL b2b_bubble respack=%b wr_done=%b reqcyc=%b expected 1 1 0", ack, wr_done, bus_if.reqcyc);
        end
        @(negedge clk); #1;
        total++;
        if (bus_if.reqcyc !== 1'b1 || bus_if.req !== 64'h5000 || wr_ready !== 1'b1 || wr_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_line_b_start reqcyc=%b req=%h wr_ready=%b wr_done=%b expected 1 5000 1 0",
                     bus_if.reqcyc, bus_if.req, wr_ready, wr_done);
        end
        capture_line(0, 0);
        for (int k = 1; k < 9; k++) begin
            total++;
            if (cap[k] !== exp_beat(8'hA0, k - 1)) begin
                bad++;
                $display("FAIL b2b_b_beat%0d got=%h expected=%h", k - 1, cap[k], exp_beat(8'hA0, k - 1));
            end
        end
        respond(16'h0001, ack);
        #1;
        total++;
        if (ack !== 1'b1 || wr_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_b respack=%b wr_done=%b expected 1 1", ack, wr_done);
        end
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b expected=0", busy); end
    endtask

    task automatic test_wrong_tag();
        logic ack;
        send_req(64'h6000, 8'h50);
        capture_line(0, 0);
        respond(16'h0002, ack);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL wrong_tag_respack got=%b expected=0", ack); end
        #1;
        total++;
        if (wr_done !== 1'b0 || busy !== 1'b1 || bus_if.reqcyc !== 1'b0) begin
            bad++;
            $display("FAIL wrong_tag_stay wr_done=%b busy=%b reqcyc=%b expected 0 1 0", wr_done, busy, bus_if.reqcyc);
        end
        @(negedge clk); #1;
        respond(16'h0001, ack);
        total++;
        if (ack !== 1'b1) begin bad++; $display("FAIL wrong_tag_late_respack got=%b expected=1", ack); end
        #1;
        total++;
        if (wr_done !== 1'b1) begin bad++; $display("FAIL wrong_tag_done got=%b expected=1", wr_done); end
        respond(16'h0001, ack);
        #1;
        total++;
        if (ack !== 1'b0 || wr_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_resp_ignored respack=%b wr_done=%b busy=%b expected 0 0 0", ack, wr_done, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic done_seen;
        send_req(64'h2000, 8'h80);
        @(negedge clk);
        bus_if.reqack = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (bus_if.reqcyc !== 1'b1 || bus_if.req !== exp_beat(8'h80, 4)) begin
            bad++;
            $display("FAIL rstmid_beat4 reqcyc=%b req=%h expected 1 %h", bus_if.reqcyc, bus_if.req, exp_beat(8'h80, 4));
        end
        bus_if.reqack = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (bus_if.reqcyc !== 1'b0 || bus_if.req !== 64'h0 || bus_if.reqtag !== 16'h0 || bus_if.respack !== 1'b0 ||
            busy !== 1'b0 || wr_ready !== 1'b1 || wr_done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear reqcyc=%b req=%h reqtag=%h respack=%b busy=%b wr_ready=%b wr_done=%b expected 0 0 0 0 0 1 0",
                     bus_if.reqcyc, bus_if.req, bus_if.reqtag, bus_if.respack, busy, wr_ready, wr_done);
        end
        @(negedge clk);
        reset = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (wr_done !== 1'b0 || bus_if.reqcyc !== 1'b0) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done activity=%b expected=0", done_seen); end
        send_req(64'h3000, 8'h10);
        capture_line(0, 0);
        total++;
        if (cap_tmo !== 1'b0 || cap[0] !== 64'h3000 || cap[1] !== exp_beat(8'h10, 0) || cap[8] !== exp_beat(8'h10, 7)) begin
            bad++;
            $display("FAIL rstmid_restart addr=%h beat0=%h beat7=%h tmo=%b expected 3000 %h %h 0",
                     cap[0], cap[1], cap[8], cap_tmo, exp_beat(8'h10, 0), exp_beat(8'h10, 7));
        end
        respond(16'h0001, ack);
        #1;
        total++;
        if (ack !== 1'b1 || wr_done !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_done respack=%b wr_done=%b expected 1 1", ack, wr_done);
        end
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b0;
        wr_valid       = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        bus_if.reqack  = 1'b0;
        bus_if.respcyc = 1'b0;
        bus_if.resptag = '0;
        test_reset();
        test_single();
        test_unaligned();
        test_stall();
        test_back_to_back();
        test_wrong_tag();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
